vec_regfile_sb: RTL and testbench
=================================

VEC_REGFILE_SB -- requirements
Module: vec_regfile_sb

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 8, number of vector registers.
REQ-002 The block SHALL have parameter REG_WIDTH, default 256, bits per register.
REQ-003 The block SHALL have parameter LANE_WIDTH, default 32, bits per write-mask lane. REG_WIDTH SHALL be an integer multiple of LANE_WIDTH, giving NUM_LANES = REG_WIDTH/LANE_WIDTH.
REQ-004 The block SHALL have parameter ADDR_W, default 5, register address width, with 2^ADDR_W >= NUM_REGS.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock. All state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have ports A1 and A2, input, ADDR_W bits each: read port addresses.
REQ-008 The block SHALL have ports RD1 and RD2, output, REG_WIDTH bits each: registered read data.
REQ-009 The block SHALL have ports BUSY1 and BUSY2, output, 1 bit each: registered scoreboard bit of A1 and A2.
REQ-010 The block SHALL have port WE3, input, 1 bit: write enable.
REQ-011 The block SHALL have port A3, input, ADDR_W bits: write address.
REQ-012 The block SHALL have port WD3, input, REG_WIDTH bits: write data.
REQ-013 The block SHALL have port WM3, input, NUM_LANES bits: lane write mask, where bit k enables WD3[k*LANE_WIDTH +: LANE_WIDTH].
REQ-014 The block SHALL have port RES_EN, input, 1 bit: reserve request, which marks register RES_A busy.
REQ-015 The block SHALL have port RES_A, input, ADDR_W bits: reserve address.
REQ-016 The block SHALL have port CLR, input, 1 bit: request to re-zero the whole file.
REQ-017 The block SHALL have port READY, output, 1 bit: high in RUN state.

Function
REQ-018 FSM SHALL have two states: CLEAR (sweep) and RUN. rst or (CLR in RUN) SHALL enter CLEAR with sweep counter = 0.
REQ-019 Each CLEAR cycle SHALL zero Register[cnt] and busy[cnt], then increment cnt. After the cycle with cnt = NUM_REGS-1, the next state SHALL be RUN. A full sweep takes exactly NUM_REGS cycles.
REQ-020 In CLEAR, WE3, RES_EN and CLR SHALL be ignored, and RD1/RD2/BUSY1/BUSY2 SHALL be registered as 0.
REQ-021 In RUN with WE3 = 1 and A3 < NUM_REGS, each lane k with WM3[k] = 1 SHALL take WD3 lane k. Unmasked lanes SHALL hold their value.
REQ-022 In RUN, a write with WE3 = 1 SHALL clear busy[A3] regardless of WM3.
REQ-023 In RUN, RES_EN = 1 with RES_A < NUM_REGS SHALL set busy[RES_A]. If a reserve and a write target the same address in the same cycle, reserve SHALL win (busy = 1) while the data is still written.
REQ-024 Read latency SHALL be 1 cycle: RD1/BUSY1 in cycle t+1 reflect A1 sampled in cycle t. RD2/BUSY2 likewise for A2.
REQ-025 Bypass: if WE3 = 1 and A3 = A1 in cycle t, RD1 at t+1 SHALL show the post-write value (masked lanes new, others old). Same for RD2. BUSY1/BUSY2 SHALL show the post-update busy bit.
REQ-026 An address >= NUM_REGS SHALL read as 0 with busy 0. A write or reserve to such an address SHALL have no effect.
REQ-027 A1 = A2 SHALL return identical data on both ports.
REQ-028 CLR asserted in the same cycle as WE3 in RUN SHALL suppress the write.

Reset
REQ-029 While rst = 1 and in the cycle after its release, READY, RD1, RD2, BUSY1 and BUSY2 SHALL be 0. The FSM SHALL be in CLEAR with cnt = 0.
REQ-030 rst asserted mid-sweep or mid-write SHALL restart the sweep from cnt = 0.
REQ-031 READY SHALL rise exactly NUM_REGS cycles after the first cycle with rst = 0.
REQ-032 The block SHALL contain no initial-value preload. The register file SHALL be defined as 0 only after the sweep.

Verification
REQ-033 Reset with defaults -> READY = 0 for 8 cycles after release, then 1. Reading all addresses 0..7 -> RD = 0 and BUSY = 0.
REQ-034 Write reg 5 with all lanes 0x11111111 → next cycle write WM3 = 8'h01, WD3 lane0 = 0xAAAAAAAA → read A1 = 5 -> RD1 lane0 = 0xAAAAAAAA, lanes 1..7 = 0x11111111.
REQ-035 Same cycle WE3, A3 = A1 = 2, WD3 = all 0x5 -> RD1 = all 0x5 in the next cycle (bypass). A2 = 9 -> RD2 = 0.
REQ-036 RES_EN with RES_A = 3 -> BUSY1 (A1 = 3) = 1. A later write to 3 -> BUSY1 = 0. Simultaneous reserve and write to 3 -> BUSY1 = 1 with new data.
REQ-037 CLR in RUN with WE3 to reg 1 -> write dropped, READY low 8 cycles, all registers 0 afterwards. rst on the 4th sweep cycle -> READY rises 8 cycles after rst drops.

Source files
------------

// File: rtl/vec_regfile_sb.sv
// -----------------------------------------------------------------------------
// vec_regfile_sb
//   Vector register file with a per-register busy scoreboard.
//   NUM_REGS registers of REG_WIDTH bits, written lane-by-lane under a mask.
//   A two-state FSM (CLEAR/RUN) zeroes one register and its busy bit per
//   cycle after reset or a CLR request. Both read ports are registered with
//   write-through bypass, so a same-cycle write is visible on the next cycle.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst          : synchronous active-high reset, restarts the clear sweep
//   A1, A2       : read addresses (ADDR_W)
//   RD1, RD2     : registered read data (REG_WIDTH)
//   BUSY1, BUSY2 : registered scoreboard bit of A1 / A2
//   WE3          : write enable
//   A3           : write address
//   WD3          : write data
//   WM3          : lane write mask, bit k enables WD3[k*LANE_WIDTH +: LANE_WIDTH]
//   RES_EN       : reserve request, marks RES_A busy
//   RES_A        : reserve address
//   CLR          : request to re-zero the whole file (honoured in RUN)
//   READY        : high while in RUN
// -----------------------------------------------------------------------------
module vec_regfile_sb #(
    parameter int NUM_REGS   = 8,
    parameter int REG_WIDTH  = 256,
    parameter int LANE_WIDTH = 32,
    parameter int ADDR_W     = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_W-1:0]                A1,
    input  logic [ADDR_W-1:0]                A2,
    output logic [REG_WIDTH-1:0]             RD1,
    output logic [REG_WIDTH-1:0]             RD2,
    output logic                             BUSY1,
    output logic                             BUSY2,
    input  logic                             WE3,
    input  logic [ADDR_W-1:0]                A3,
    input  logic [REG_WIDTH-1:0]             WD3,
    input  logic [REG_WIDTH/LANE_WIDTH-1:0]  WM3,
    input  logic                             RES_EN,
    input  logic [ADDR_W-1:0]                RES_A,
    input  logic                             CLR,
    output logic                             READY
);

    localparam int NUM_LANES = REG_WIDTH / LANE_WIDTH;
    localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W:0]  NREGS_A  = (ADDR_W+1)'(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    generate
        if ((REG_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lane
            $error("REG_WIDTH must be a multiple of LANE_WIDTH");
        end
        if ((2 ** ADDR_W) < NUM_REGS) begin : g_bad_addr
            $error("ADDR_W too narrow for NUM_REGS");
        end
    endgenerate

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Replace the lanes selected by mask with the matching lanes of new_v.
    function automatic logic [REG_WIDTH-1:0] lane_merge(
        input logic [REG_WIDTH-1:0] old_v,
        input logic [REG_WIDTH-1:0] new_v,
        input logic [NUM_LANES-1:0] mask
    );
        logic [REG_WIDTH-1:0] r;
        r = old_v;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (mask[k]) begin
                r[k*LANE_WIDTH +: LANE_WIDTH] = new_v[k*LANE_WIDTH +: LANE_WIDTH];
            end
        end
        return r;
    endfunction

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic [REG_WIDTH-1:0] mem_q [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic [REG_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic                 busy1_q, busy1_d, busy2_q, busy2_d;

    logic                 run, sweep;
    logic                 a1_ok, a2_ok, a3_ok, ra_ok;
    logic [IDX_W-1:0]     a1_idx, a2_idx, a3_idx, ra_idx;
    logic                 we_eff, res_eff;
    logic [REG_WIDTH-1:0] wr_data;

    assign run   = !rst && (state_q == ST_RUN);
    assign sweep = !rst && (state_q == ST_CLEAR);

    assign a1_ok = ({1'b0, A1}    < NREGS_A);
    assign a2_ok = ({1'b0, A2}    < NREGS_A);
    assign a3_ok = ({1'b0, A3}    < NREGS_A);
    assign ra_ok = ({1'b0, RES_A} < NREGS_A);

    assign a1_idx = A1[IDX_W-1:0];
    assign a2_idx = A2[IDX_W-1:0];
    assign a3_idx = A3[IDX_W-1:0];
    assign ra_idx = RES_A[IDX_W-1:0];

    // CLR takes priority over any same-cycle write or reserve; the file is
    // about to be wiped, so nothing issued alongside it may land.
    assign we_eff  = run && !CLR && WE3 && a3_ok;
    assign res_eff = run && !CLR && RES_EN && ra_ok;

    // Post-write image of the addressed register, shared by the array
    // update and the read bypass.
    assign wr_data = lane_merge(mem_q[a3_idx], WD3, WM3);

    // FSM next state and sweep counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (CLR) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Scoreboard update. Reserve is applied after write so it wins on a
    // same-address collision.
    always_comb begin
        busy_d = busy_q;
        if (sweep) begin
            busy_d[cnt_q] = 1'b0;
        end else begin
            if (we_eff) begin
                busy_d[a3_idx] = 1'b0;
            end
            if (res_eff) begin
                busy_d[ra_idx] = 1'b1;
            end
        end
    end

    // Read ports with write-through bypass; out-of-range reads return 0.
    always_comb begin
        rd1_d   = '0;
        rd2_d   = '0;
        busy1_d = 1'b0;
        busy2_d = 1'b0;
        if (run) begin
            if (a1_ok) begin
                rd1_d   = (we_eff && (A1 == A3)) ? wr_data : mem_q[a1_idx];
                busy1_d = busy_d[a1_idx];
            end
            if (a2_ok) begin
                rd2_d   = (we_eff && (A2 == A3)) ? wr_data : mem_q[a2_idx];
                busy2_d = busy_d[a2_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            busy1_q <= 1'b0;
            busy2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            busy1_q <= busy1_d;
            busy2_q <= busy2_d;
        end
    end

    // Array storage: no reset, contents become defined through the sweep.
    always_ff @(posedge clk) begin
        busy_q <= busy_d;
        if (sweep) begin
            mem_q[cnt_q] <= '0;
        end else if (we_eff) begin
            mem_q[a3_idx] <= wr_data;
        end
    end

    assign RD1   = rd1_q;
    assign RD2   = rd2_q;
    assign BUSY1 = busy1_q;
    assign BUSY2 = busy2_q;
    assign READY = (state_q == ST_RUN);

endmodule

// File: tb/tb_vec_regfile_sb.sv
module tb_vec_regfile_sb;

    localparam int NUM_REGS   = 8;
    localparam int REG_WIDTH  = 256;
    localparam int LANE_WIDTH = 32;
    localparam int ADDR_W     = 5;
    localparam int NUM_LANES  = REG_WIDTH / LANE_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [ADDR_W-1:0]     A1, A2, A3, RES_A;
    logic [REG_WIDTH-1:0]  RD1, RD2, WD3;
    logic                  BUSY1, BUSY2, WE3, RES_EN, CLR, READY;
    logic [NUM_LANES-1:0]  WM3;

    int pass_cnt  = 0;
    int total_cnt = 0;

    vec_regfile_sb #(
        .NUM_REGS  (NUM_REGS),
        .REG_WIDTH (REG_WIDTH),
        .LANE_WIDTH(LANE_WIDTH),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .A1    (A1),
        .A2    (A2),
        .RD1   (RD1),
        .RD2   (RD2),
        .BUSY1 (BUSY1),
        .BUSY2 (BUSY2),
        .WE3   (WE3),
        .A3    (A3),
        .WD3   (WD3),
        .WM3   (WM3),
        .RES_EN(RES_EN),
        .RES_A (RES_A),
        .CLR   (CLR),
        .READY (READY)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        WE3 = 1'b0; A3 = '0; WD3 = '0; WM3 = '0;
        RES_EN = 1'b0; RES_A = '0; CLR = 1'b0;
        A1 = '0; A2 = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step(); step(); step();
        total_cnt++;
        if ({READY, BUSY1, BUSY2} !== 3'b000 || RD1 !== '0 || RD2 !== '0)
            $display("FAIL reset_outputs got READY=%0b B1=%0b B2=%0b RD1=%h expected all 0", READY, BUSY1, BUSY2, RD1);
        else pass_cnt++;
        rst = 1'b0;
        total_cnt++;
        if (READY !== 1'b0) $display("FAIL ready_release got %0b expected 0", READY);
        else pass_cnt++;
        for (int i = 1; i <= NUM_REGS; i++) begin
            step();
            total_cnt++;
            if (READY !== (i == NUM_REGS))
                $display("FAIL ready_sweep cycle %0d got %0b expected %0b", i, READY, (i == NUM_REGS));
            else pass_cnt++;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            A1 = ADDR_W'(i); A2 = ADDR_W'(i);
            step();
            total_cnt++;
            if (RD1 !== '0 || RD2 !== '0 || BUSY1 !== 1'b0 || BUSY2 !== 1'b0)
                $display("FAIL reset_read reg %0d got RD1=%h BUSY1=%0b expected 0/0", i, RD1, BUSY1);
            else pass_cnt++;
        end
    endtask

    task automatic test_masked_write();
        logic [REG_WIDTH-1:0] exp;
        idle_inputs();
        WE3 = 1'b1; A3 = 5; WM3 = 8'hFF; WD3 = {8{32'h11111111}};
        step();
        WM3 = 8'h01; WD3 = {8{32'hAAAAAAAA}};
        step();
        WE3 = 1'b0; A1 = 5;
        step();
        exp = {{7{32'h11111111}}, 32'hAAAAAAAA};
        total_cnt++;
        if (RD1 !== exp) $display("FAIL masked_write got %h expected %h", RD1, exp);
        else pass_cnt++;
        // partial write bypassed into the same-cycle read
        WE3 = 1'b1; A3 = 5; WM3 = 8'h02; WD3 = {8{32'h22222222}}; A1 = 5;
        step();
        exp = {{6{32'h11111111}}, 32'h22222222, 32'hAAAAAAAA};
        total_cnt++;
        if (RD1 !== exp) $display("FAIL masked_bypass got %h expected %h", RD1, exp);
        else pass_cnt++;
        // write to address 13 aliases reg 5 in the low bits but must be dropped
        WE3 = 1'b1; A3 = 13; WM3 = 8'hFF; WD3 = {8{32'hDEADBEEF}};
        step();
        WE3 = 1'b0; A1 = 5;
        step();
        total_cnt++;
        if (RD1 !== exp) $display("FAIL oob_write got %h expected %h", RD1, exp);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        idle_inputs();
        WE3 = 1'b1; A3 = 2; WM3 = 8'hFF; WD3 = {8{32'h00000005}}; A1 = 2; A2 = 9;
        step();
        total_cnt++;
        if (RD1 !== {8{32'h00000005}}) $display("FAIL bypass_rd1 got %h expected %h", RD1, {8{32'h00000005}});
        else pass_cnt++;
        total_cnt++;
        if (RD2 !== '0 || BUSY2 !== 1'b0) $display("FAIL oob_read got RD2=%h BUSY2=%0b expected 0/0", RD2, BUSY2);
        else pass_cnt++;
        WE3 = 1'b0; A1 = 2; A2 = 2;
        step();
        total_cnt++;
        if (RD1 !== {8{32'h00000005}} || RD2 !== {8{32'h00000005}})
            $display("FAIL same_addr got RD1=%h RD2=%h expected %h", RD1, RD2, {8{32'h00000005}});
        else pass_cnt++;
    endtask

    task automatic test_reserve();
        idle_inputs();
        RES_EN = 1'b1; RES_A = 3; A1 = 3;
        step();
        total_cnt++;
        if (BUSY1 !== 1'b1) $display("FAIL reserve_bypass got %0b expected 1", BUSY1);
        else pass_cnt++;
        RES_EN = 1'b0;
        step();
        total_cnt++;
        if (BUSY1 !== 1'b1) $display("FAIL reserve_hold got %0b expected 1", BUSY1);
        else pass_cnt++;
        // empty mask still releases the register
        WE3 = 1'b1; A3 = 3; WM3 = 8'h00; WD3 = {8{32'hFFFFFFFF}};
        step();
        WE3 = 1'b0;
        total_cnt++;
        if (BUSY1 !== 1'b0) $display("FAIL write_release got %0b expected 0", BUSY1);
        else pass_cnt++;
        step();
        total_cnt++;
        if (BUSY1 !== 1'b0 || RD1 !== '0) $display("FAIL nomask_write got BUSY1=%0b RD1=%h expected 0/0", BUSY1, RD1);
        else pass_cnt++;
        RES_EN = 1'b1; RES_A = 3; WE3 = 1'b1; A3 = 3; WM3 = 8'hFF; WD3 = {8{32'h33333333}};
        step();
        RES_EN = 1'b0; WE3 = 1'b0;
        step();
        total_cnt++;
        if (BUSY1 !== 1'b1 || RD1 !== {8{32'h33333333}})
            $display("FAIL reserve_vs_write got BUSY1=%0b RD1=%h expected 1/%h", BUSY1, RD1, {8{32'h33333333}});
        else pass_cnt++;
        // reserve to 12 aliases reg 4 in the low bits but must be dropped
        RES_EN = 1'b1; RES_A = 12; A1 = 4; A2 = 3;
        step();
        RES_EN = 1'b0;
        step();
        total_cnt++;
        if (BUSY1 !== 1'b0 || BUSY2 !== 1'b1)
            $display("FAIL oob_reserve got BUSY1=%0b BUSY2=%0b expected 0/1", BUSY1, BUSY2);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        idle_inputs();
        CLR = 1'b1; WE3 = 1'b1; A3 = 1; WM3 = 8'hFF; WD3 = {8{32'h77777777}}; A1 = 5;
        step();
        CLR = 1'b0; WE3 = 1'b0;
        total_cnt++;
        if (READY !== 1'b0) $display("FAIL clr_ready got %0b expected 0", READY);
        else pass_cnt++;
        for (int i = 1; i <= NUM_REGS; i++) begin
            step();
            // writes and reserves to reg 0 during the sweep must be ignored
            WE3 = (i < NUM_REGS - 1); RES_EN = (i < NUM_REGS - 1);
            A3 = 0; RES_A = 0; WD3 = {8{32'h99999999}};
            total_cnt++;
            if (READY !== (i == NUM_REGS) || RD1 !== '0)
                $display("FAIL clr_sweep cycle %0d got READY=%0b RD1=%h expected %0b/0", i, READY, RD1, (i == NUM_REGS));
            else pass_cnt++;
        end
        idle_inputs();
        for (int i = 0; i < NUM_REGS; i++) begin
            A1 = ADDR_W'(i); A2 = ADDR_W'(NUM_REGS - 1 - i);
            step();
            total_cnt++;
            if (RD1 !== '0 || BUSY1 !== 1'b0 || RD2 !== '0 || BUSY2 !== 1'b0)
                $display("FAIL clr_read reg %0d got RD1=%h BUSY1=%0b expected 0/0", i, RD1, BUSY1);
            else pass_cnt++;
        end
    endtask

    task automatic test_rst_midsweep();
        idle_inputs();
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++;
        if (READY !== 1'b0) $display("FAIL midsweep_release got %0b expected 0", READY);
        else pass_cnt++;
        for (int i = 1; i <= NUM_REGS; i++) begin
            step();
            total_cnt++;
            if (READY !== (i == NUM_REGS))
                $display("FAIL midsweep_ready cycle %0d got %0b expected %0b", i, READY, (i == NUM_REGS));
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_masked_write();
        test_bypass();
        test_reserve();
        test_clear();
        test_rst_midsweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
